// File: rtl/ap_pass_sequencer_pkg.sv
// ap_seq_pkg: op/state enums, ABS pass code and compare-key LUT shared by the pass sequencer.
package ap_seq_pkg;
    typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_ABS, OP_RSV} op_e;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CMP, S_WR, S_DONE} state_e;
    localparam logic [2:0] PASS_ABS = 3'd4;
    localparam logic [3:0] KEY_LUT = 4'b0110;
    function automatic logic key_lut(input logic pass0, input logic col0);
        return KEY_LUT[{pass0, col0}];
    endfunction
endpackage

// File: rtl/ap_pass_sequencer_if.sv
// ap_pass_sequencer_if: command handshake from the decoder plus the array control lines.
interface ap_pass_sequencer_if #(parameter int COL_W = 3);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cell_load_n;
    logic [COL_W-1:0] col_sel;
    logic             mask;
    logic             key;
    logic [2:0]       pass;
    logic             abs_opt;
    logic             wr_phase;
    logic             done;
    logic             err;
    modport master (output cmd_valid, cmd_op,
                    input  cmd_ready, cell_load_n, col_sel, mask, key, pass, abs_opt, wr_phase, done, err);
    modport slave  (input  cmd_valid, cmd_op,
                    output cmd_ready, cell_load_n, col_sel, mask, key, pass, abs_opt, wr_phase, done, err);
endinterface

// File: rtl/ap_pass_sequencer_col_pass_cnt.sv
// ap_col_pass_cnt: nested pass/column counter; ABS runs a single fixed pass code per column.
module ap_col_pass_cnt
    import ap_seq_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int N_PASS = 4,
    parameter int COL_W  = $clog2(WORD_W)
) (
    input  logic             clk,
    input  logic             rstIn,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             abs_i,
    output logic [COL_W-1:0] col_o,
    output logic [2:0]       pass_o,
    output logic             col0_d_o,
    output logic             pass0_d_o,
    output logic             last_o
);
    logic [COL_W-1:0] col_q, col_d;
    logic [2:0]       pass_q, pass_d, pass_first;
    logic             last_pass;
    always_comb begin
        pass_first = abs_i ? PASS_ABS : 3'd0;
        last_pass  = abs_i || pass_q == 3'(N_PASS - 1);
        last_o     = last_pass && col_q == COL_W'(WORD_W - 1);
        // the final step returns both counters to zero so idle outputs match reset
        col_d  = (start_i || (step_i && last_o)) ? '0 :
                 (step_i && last_pass) ? col_q + COL_W'(1) : col_q;
        pass_d = start_i ? pass_first :
                 !step_i ? pass_q :
                 last_o ? 3'd0 :
                 last_pass ? pass_first : pass_q + 3'd1;
    end
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            col_q  <= '0;
            pass_q <= '0;
        end else begin
            col_q  <= col_d;
            pass_q <= pass_d;
        end
    end
    assign col_o     = col_q;
    assign pass_o    = pass_q;
    assign col0_d_o  = col_d[0];
    assign pass0_d_o = pass_d[0];
endmodule

// File: rtl/ap_pass_sequencer.sv
// ap_pass_sequencer: turns LOAD/ADD/ABS commands into per-column compare/write cycles for the cell array.
// Define AP_ABS_EN to accept ABS; otherwise ABS is rejected like the reserved op.
module ap_pass_sequencer
    import ap_seq_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int N_PASS = 4,
    parameter int COL_W  = $clog2(WORD_W)
) (
    input  logic               clk,
    input  logic               rstIn,
    ap_pass_sequencer_if.slave bus
);
`ifdef AP_ABS_EN
    localparam logic ABS_EN = 1'b1;
`else
    localparam logic ABS_EN = 1'b0;
`endif
    state_e           state_q, state_d;
    op_e              op;
    logic             illegal, start, step, last, col0_nx, pass0_nx;
    logic             abs_q, abs_d;
    logic [COL_W-1:0] col;
    logic [2:0]       pass;
    logic ready_q, ready_d, load_n_q, load_n_d, mask_q, mask_d, key_q, key_d;
    logic abs_opt_q, abs_opt_d, wr_q, wr_d, done_q, done_d, err_q, err_d;
    ap_col_pass_cnt #(.WORD_W(WORD_W), .N_PASS(N_PASS), .COL_W(COL_W)) u_cnt (
        .clk       (clk),
        .rstIn     (rstIn),
        .start_i   (start),
        .step_i    (step),
        .abs_i     (abs_d),
        .col_o     (col),
        .pass_o    (pass),
        .col0_d_o  (col0_nx),
        .pass0_d_o (pass0_nx),
        .last_o    (last)
    );
    always_comb begin
        op      = op_e'(bus.cmd_op);
        illegal = op == OP_RSV || (op == OP_ABS && !ABS_EN);
        state_d = state_q;
        abs_d   = abs_q;
        start   = 1'b0;
        step    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: if (bus.cmd_valid) begin
                err_d   = illegal;
                start   = !illegal && op != OP_LOAD;
                abs_d   = !illegal && op == OP_ABS;
                state_d = illegal ? S_IDLE : (op == OP_LOAD ? S_LOAD : S_CMP);
            end
            S_LOAD: state_d = S_DONE;
            S_CMP:  state_d = S_WR;
            S_WR: begin
                step    = 1'b1;
                state_d = last ? S_DONE : S_CMP;
            end
            S_DONE: begin
                state_d = S_IDLE;
                abs_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        // outputs are decoded from the next state so every control line leaves a flop
        ready_d   = state_d == S_IDLE;
        load_n_d  = state_d != S_LOAD;
        mask_d    = state_d == S_CMP;
        key_d     = state_d == S_CMP && key_lut(pass0_nx, col0_nx);
        abs_opt_d = (state_d == S_CMP || state_d == S_WR) && abs_d;
        wr_d      = state_d == S_WR;
        done_d    = state_d == S_DONE;
    end
    always_ff @(posedge clk or negedge rstIn) begin
        if (!rstIn) begin
            state_q   <= S_IDLE;
            abs_q     <= 1'b0;
            ready_q   <= 1'b1;
            load_n_q  <= 1'b1;
            mask_q    <= 1'b0;
            key_q     <= 1'b0;
            abs_opt_q <= 1'b0;
            wr_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            abs_q     <= abs_d;
            ready_q   <= ready_d;
            load_n_q  <= load_n_d;
            mask_q    <= mask_d;
            key_q     <= key_d;
            abs_opt_q <= abs_opt_d;
            wr_q      <= wr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end
    assign bus.cmd_ready   = ready_q;
    assign bus.cell_load_n = load_n_q;
    assign bus.col_sel     = col;
    assign bus.mask        = mask_q;
    assign bus.key         = key_q;
    assign bus.pass        = pass;
    assign bus.abs_opt     = abs_opt_q;
    assign bus.wr_phase    = wr_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ap_pass_sequencer.sv
// tb_ap_pass_sequencer: directed and random commands checked cycle by cycle against a timeline model.
module tb_ap_pass_sequencer;
    localparam int WORD_W = 8;
    localparam int N_PASS = 4;
    localparam int COL_W  = 3;
`ifdef AP_ABS_EN
    localparam bit ABS_EN = 1'b1;
`else
    localparam bit ABS_EN = 1'b0;
`endif
    // {ready, load_n, col[2:0], mask, key, pass[2:0], abs_opt, wr_phase, done, err}
    localparam logic [13:0] IDLE_V = 14'b11_000_0_0_000_0_0_0_0;

    logic clk = 1'b0;
    logic rstIn = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [13:0] obs_v;

    always #5 clk = ~clk;

    ap_pass_sequencer_if #(.COL_W(COL_W)) bus ();
    ap_pass_sequencer #(.WORD_W(WORD_W), .N_PASS(N_PASS)) dut (.clk(clk), .rstIn(rstIn), .bus(bus));

    assign obs_v = {bus.cmd_ready, bus.cell_load_n, bus.col_sel, bus.mask, bus.key, bus.pass,
                    bus.abs_opt, bus.wr_phase, bus.done, bus.err};

    function automatic bit is_illegal(int op);
        return op == 3 || (op == 2 && !ABS_EN);
    endfunction

    function automatic logic [13:0] pack(bit ready, bit load_n, int col, bit mask, bit key, int pass,
                                         bit abs_opt, bit wr, bit done, bit err);
        logic [2:0] c, p;
        c = 3'(col);
        p = 3'(pass);
        return {ready, load_n, c, mask, key, p, abs_opt, wr, done, err};
    endfunction

    // cycles observed after the accept edge, including the first idle cycle
    function automatic int cmd_len(int op);
        if (is_illegal(op)) return 2;
        if (op == 0) return 3;
        return (op == 2) ? 2 * WORD_W + 2 : 2 * WORD_W * N_PASS + 2;
    endfunction

    // expected outputs k cycles after accept, from the command timeline
    function automatic logic [13:0] exp_vec(int op, int k);
        bit abs_cmd;
        int n, i, col, pass;
        bit wr, key;
        abs_cmd = (op == 2);
        if (is_illegal(op)) return (k == 1) ? pack(1, 1, 0, 0, 0, 0, 0, 0, 0, 1) : IDLE_V;
        if (op == 0) return (k == 1) ? pack(0, 0, 0, 0, 0, 0, 0, 0, 0, 0) :
                            (k == 2) ? pack(0, 1, 0, 0, 0, 0, 0, 0, 1, 0) : IDLE_V;
        n = abs_cmd ? WORD_W : WORD_W * N_PASS;
        if (k > 2 * n + 1) return IDLE_V;
        if (k == 2 * n + 1) return pack(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        i    = (k - 1) / 2;
        wr   = ((k - 1) % 2) == 1;
        col  = abs_cmd ? i : i / N_PASS;
        pass = abs_cmd ? 4 : i % N_PASS;
        key  = !wr && (((pass ^ col) & 1) == 1);
        return pack(0, 1, col, !wr, key, pass, abs_cmd, wr, 0, 0);
    endfunction

    task automatic check(string tag, int k, logic [13:0] exp);
        n_cmp++;
        assert (obs_v === exp) else begin
            n_bad++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, k, obs_v, exp);
        end
    endtask

    // call at a negedge with the DUT idle; returns at the negedge of the first idle cycle
    task automatic run_cmd(int op, bit hold);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'(op);
        @(posedge clk);
        for (int k = 1; k <= cmd_len(op); k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.cmd_valid = hold && !is_illegal(op);
                bus.cmd_op    = 2'($urandom_range(0, 3));
            end
            check($sformatf("op%0d", op), k, exp_vec(op, k));
        end
    endtask

    task automatic idle_cycles(int n);
        bus.cmd_valid = 1'b0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check("idle", k, IDLE_V);
        end
    endtask

    initial begin
        bit hold;
        int op;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        #2 rstIn = 1'b0;
        #1 check("reset", 0, IDLE_V);
        repeat (2) @(negedge clk);
        rstIn = 1'b1;
        idle_cycles(2);
        run_cmd(0, 1'b0);
        idle_cycles(1);
        run_cmd(1, 1'b1);
        run_cmd(0, 1'b0);
        run_cmd(2, 1'b0);
        idle_cycles(1);
        run_cmd(3, 1'b0);
        idle_cycles(1);
        // reset in the middle of an ADD aborts it without a done pulse
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd1;
        @(posedge clk);
        repeat (11) @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("add_mid", 11, exp_vec(1, 11));
        rstIn = 1'b0;
        #1 check("rst_mid", 0, IDLE_V);
        @(negedge clk);
        check("rst_hold", 0, IDLE_V);
        rstIn = 1'b1;
        idle_cycles(3);
        for (int j = 0; j < 20; j++) begin
            op   = int'($urandom_range(0, 3));
            hold = 1'($urandom_range(0, 1));
            run_cmd(op, hold);
            if (!hold || is_illegal(op)) idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
